// File: rtl/sb_config_ctrl.sv
// Serial configuration loader for the 5x4 switchbox: assembles 18 route entries,
// validates each one, then commits the whole image to cfg_active in a single edge.
//
// state  | meaning
// IDLE   | waiting for cfg_start; committed image held on cfg_active
// LOAD   | shifting frame bits into the shadow image
// CHECK  | validating one shadow entry per cycle
// COMMIT | copying shadow to cfg_active, pulsing cfg_done
module sb_config_ctrl #(
   parameter int N_TB  = 5,
   parameter int N_LR  = 4,
   parameter int ENT_W = 6,
   parameter int N_ENT = 2*N_TB + 2*N_LR
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_start,
   input  logic                     cfg_bit_valid,
   input  logic                     cfg_bit,
   output logic                     cfg_busy,
   output logic                     cfg_done,
   output logic                     cfg_err,
   output logic [4:0]               cfg_err_ent,
   output logic [N_ENT*ENT_W-1:0]   cfg_active
);

   localparam int FRAME_W = N_ENT*ENT_W;
   localparam int PW      = 7;

   localparam logic [2:0] SEL_OFF   = 3'd0;
   localparam logic [2:0] SEL_TOP   = 3'd1;
   localparam logic [2:0] SEL_RIGHT = 3'd2;
   localparam logic [2:0] SEL_BOT   = 3'd3;
   localparam logic [2:0] SEL_LEFT  = 3'd4;
   localparam logic [2:0] TB_LIM    = 3'(N_TB);
   localparam logic [2:0] LR_LIM    = 3'(N_LR);
   localparam logic [4:0] B_BOT     = 5'(N_TB);
   localparam logic [4:0] B_LEFT    = 5'(2*N_TB);
   localparam logic [4:0] B_RIGHT   = 5'(2*N_TB + N_LR);

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [4:0]           ptr_q, ptr_d;
   logic [2:0]           sub_q, sub_d;
   logic [FRAME_W-1:0]   shadow_q, shadow_d;
   logic [FRAME_W-1:0]   active_q, active_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [4:0]           err_ent_q, err_ent_d;

   logic [PW-1:0]        wr_pos;
   logic [ENT_W-1:0]     chk_ent;
   logic [2:0]           chk_sel, chk_idx;
   logic [2:0]           own_side;
   logic [4:0]           own_idx;
   logic                 chk_fail;

   // ptr_q doubles as the entry being loaded (LOAD) and the entry being checked (CHECK)
   always_comb begin
      wr_pos  = PW'(int'(ptr_q)*ENT_W + (ENT_W-1) - int'(sub_q));
      chk_ent = shadow_q[int'(ptr_q)*ENT_W +: ENT_W];
      chk_sel = chk_ent[2:0];
      chk_idx = chk_ent[5:3];

      own_side = SEL_TOP;
      own_idx  = ptr_q;
      if (ptr_q >= B_RIGHT) begin
         own_side = SEL_RIGHT;
         own_idx  = ptr_q - B_RIGHT;
      end else if (ptr_q >= B_LEFT) begin
         own_side = SEL_LEFT;
         own_idx  = ptr_q - B_LEFT;
      end else if (ptr_q >= B_BOT) begin
         own_side = SEL_BOT;
         own_idx  = ptr_q - B_BOT;
      end

      chk_fail = (chk_sel > SEL_LEFT)
              || (((chk_sel == SEL_TOP) || (chk_sel == SEL_BOT)) && (chk_idx >= TB_LIM))
              || (((chk_sel == SEL_RIGHT) || (chk_sel == SEL_LEFT)) && (chk_idx >= LR_LIM))
              || ((chk_sel != SEL_OFF) && (chk_sel == own_side) && ({2'b00, chk_idx} == own_idx));
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      ptr_d     = ptr_q;
      sub_d     = sub_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      done_d    = 1'b0;
      err_d     = err_q;
      err_ent_d = err_ent_q;

      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d   = LOAD;
               bit_cnt_d = '0;
               ptr_d     = '0;
               sub_d     = '0;
               err_d     = 1'b0;
               err_ent_d = '0;
            end
         end
         LOAD: begin
            if (cfg_bit_valid) begin
               shadow_d[wr_pos] = cfg_bit;
               if (bit_cnt_q == PW'(FRAME_W-1)) begin
                  state_d = CHECK;
                  ptr_d   = '0;
                  sub_d   = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (sub_q == 3'(ENT_W-1)) begin
                     sub_d = '0;
                     ptr_d = ptr_q + 1'b1;
                  end else begin
                     sub_d = sub_q + 1'b1;
                  end
               end
            end
         end
         CHECK: begin
            if (chk_fail) begin
               err_d     = 1'b1;
               err_ent_d = ptr_q;
               done_d    = 1'b1;
               state_d   = IDLE;
            end else if (ptr_q == 5'(N_ENT-1)) begin
               state_d = COMMIT;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         COMMIT: begin
            active_d = shadow_q;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         ptr_q     <= '0;
         sub_q     <= '0;
         shadow_q  <= '0;
         active_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         err_ent_q <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         ptr_q     <= ptr_d;
         sub_q     <= sub_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         err_ent_q <= err_ent_d;
      end
   end

   assign cfg_busy    = busy_q;
   assign cfg_done    = done_q;
   assign cfg_err     = err_q;
   assign cfg_err_ent = err_ent_q;
   assign cfg_active  = active_q;

endmodule

// File: tb/tb_sb_config_ctrl.sv
// Scoreboard bench for sb_config_ctrl: directed frames push expected results,
// a negedge monitor pops and compares on every cfg_done.
module tb_sb_config_ctrl;

   localparam int FW = 108;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_start, cfg_bit_valid, cfg_bit;
   logic          cfg_busy, cfg_done, cfg_err;
   logic [4:0]    cfg_err_ent;
   logic [FW-1:0] cfg_active;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int busy_cnt = 0;
   int start_c, last_c;

   typedef struct {
      logic          err;
      logic [4:0]    ent;
      logic [FW-1:0] act;
      int            start_c;
      int            done_c;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   sb_config_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_start     (cfg_start),
      .cfg_bit_valid (cfg_bit_valid),
      .cfg_bit       (cfg_bit),
      .cfg_busy      (cfg_busy),
      .cfg_done      (cfg_done),
      .cfg_err       (cfg_err),
      .cfg_err_ent   (cfg_err_ent),
      .cfg_active    (cfg_active)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         busy_cnt = 0;
      end else begin
         if (cfg_done) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_done", 128'(1), 128'(0));
            end else begin
               mon_e = sb_q.pop_front();
               chk("done_err", 128'(cfg_err), 128'(mon_e.err));
               if (mon_e.err) chk("done_err_ent", 128'(cfg_err_ent), 128'(mon_e.ent));
               chk("done_active", 128'(cfg_active), 128'(mon_e.act));
               chk("done_cycle", 128'(cyc), 128'(mon_e.done_c));
               chk("busy_len", 128'(busy_cnt), 128'(mon_e.done_c - mon_e.start_c));
               chk("busy_at_done", 128'(cfg_busy), 128'(0));
            end
         end
         if (cfg_busy) busy_cnt++;
         else busy_cnt = 0;
      end
   end

   // Sends a frame; stops early (returns) after bit stop_at when stop_at >= 0.
   task automatic send_frame(input logic [FW-1:0] img, input bit gapped, input int stop_at);
      @(negedge clk);
      cfg_start     = 1'b1;
      cfg_bit_valid = 1'b1;
      cfg_bit       = 1'b1;
      @(negedge clk);
      start_c   = cyc;
      cfg_start = 1'b0;
      for (int n = 0; n < FW; n++) begin
         if (gapped) begin
            while ($urandom_range(0, 9) >= 4) begin
               cfg_bit_valid = 1'b0;
               cfg_bit       = 1'($urandom_range(0, 1));
               cfg_start     = ($urandom_range(0, 3) == 0);
               @(negedge clk);
            end
            cfg_start = ($urandom_range(0, 3) == 0);
         end
         cfg_bit_valid = 1'b1;
         cfg_bit       = img[6*(n/6) + 5 - (n%6)];
         @(negedge clk);
         if (n == stop_at) begin
            cfg_bit_valid = 1'b0;
            cfg_start     = 1'b0;
            return;
         end
      end
      last_c    = cyc;
      cfg_start = 1'b0;
      if (gapped) begin
         for (int i = 0; i < 5; i++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
      end
      cfg_bit_valid = 1'b0;
   endtask

   task automatic expect_result(input logic err, input logic [4:0] ent, input logic [FW-1:0] act,
                                input int lat);
      exp_t e;
      e.err     = err;
      e.ent     = ent;
      e.act     = act;
      e.start_c = start_c;
      e.done_c  = last_c + lat;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      int t = 0;
      while (sb_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("drain_timeout", 128'(sb_q.size()), 128'(0));
      repeat (3) @(negedge clk);
   endtask

   logic [FW-1:0] img_a, img_bad, img_c, img_b;

   initial begin
      rst = 1'b1;
      cfg_start = 1'b0;
      cfg_bit_valid = 1'b0;
      cfg_bit = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("idle_outputs", 128'({cfg_active, cfg_busy, cfg_done, cfg_err}), 128'(0));
      end

      // top0 <- right3, right0 <- top0
      img_a = '0;
      img_a[0*6 +: 6]  = 6'h1A;
      img_a[14*6 +: 6] = 6'h01;
      send_frame(img_a, 1'b0, -1);
      chk("gapfree_len", 128'(last_c - start_c), 128'(108));
      expect_result(1'b0, 5'd0, img_a, 19);
      drain();

      // left0 <- left index 4: out of range
      img_bad = img_a;
      img_bad[10*6 +: 6] = 6'b100_100;
      send_frame(img_bad, 1'b0, -1);
      expect_result(1'b1, 5'd10, img_a, 11);
      drain();

      // illegal sel 6 on entry 3
      img_bad = img_a;
      img_bad[3*6 +: 6] = 6'b000_110;
      send_frame(img_bad, 1'b0, -1);
      expect_result(1'b1, 5'd3, img_a, 4);
      drain();

      // bottom0 <- bottom0: self-loop
      img_bad = img_a;
      img_bad[5*6 +: 6] = 6'b000_011;
      send_frame(img_bad, 1'b0, -1);
      expect_result(1'b1, 5'd5, img_a, 6);
      drain();
      chk("err_sticky", 128'({cfg_err, cfg_err_ent}), 128'({1'b1, 5'd5}));

      // bottom0 <- bottom1 is legal
      img_c = img_a;
      img_c[5*6 +: 6] = 6'b001_011;
      send_frame(img_c, 1'b0, -1);
      expect_result(1'b0, 5'd0, img_c, 19);
      drain();
      chk("err_cleared", 128'(cfg_err), 128'(0));

      send_frame(img_a, 1'b1, -1);
      expect_result(1'b0, 5'd0, img_a, 19);
      drain();

      send_frame(img_c, 1'b0, 40);
      chk("pre_rst_active", 128'(cfg_active), 128'(img_a));
      chk("pre_rst_busy", 128'(cfg_busy), 128'(1));
      #2 rst = 1'b1;
      #1;
      chk("rst_async_busy", 128'(cfg_busy), 128'(0));
      chk("rst_async_active", 128'(cfg_active), 128'(0));
      chk("rst_async_err", 128'({cfg_err, cfg_err_ent, cfg_done}), 128'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", 128'({cfg_active, cfg_busy}), 128'(0));

      // bottom4 <- left3, right3 <- top4
      img_b = '0;
      img_b[9*6 +: 6]  = 6'b011_100;
      img_b[17*6 +: 6] = 6'b100_001;
      send_frame(img_b, 1'b0, -1);
      expect_result(1'b0, 5'd0, img_b, 19);
      drain();
      chk("final_active", 128'(cfg_active), 128'(img_b));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
